// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit signal bundle: pipeline status from ID/EX/MEM in, stall/flush controls and counters out.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       ID_Rn;
   logic [4:0]       ID_Rm;
   logic             ID_UsesRn;
   logic             ID_UsesRm;
   logic             EX_MemRead;
   logic [4:0]       EX_Rd;
   logic             MEM_MemAccess;
   logic             MEM_BranchTaken;
   logic             PC_Stall;
   logic             IFID_Stall;
   logic             IDEX_Stall;
   logic             EXMEM_Stall;
   logic             IFID_Flush;
   logic             IDEX_Flush;
   logic             EXMEM_Flush;
   logic [1:0]       State;
   logic [CNT_W-1:0] StallCycles;
   logic [CNT_W-1:0] FlushEvents;

   modport master (
      output ID_Rn, ID_Rm, ID_UsesRn, ID_UsesRm, EX_MemRead, EX_Rd,
             MEM_MemAccess, MEM_BranchTaken,
      input  PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall,
             IFID_Flush, IDEX_Flush, EXMEM_Flush, State, StallCycles, FlushEvents
   );

   modport slave (
      input  ID_Rn, ID_Rm, ID_UsesRn, ID_UsesRm, EX_MemRead, EX_Rd,
             MEM_MemAccess, MEM_BranchTaken,
      output PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall,
             IFID_Flush, IDEX_Flush, EXMEM_Flush, State, StallCycles, FlushEvents
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch redirects,
// multi-cycle memory freezes, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int MEM_WAIT_CYCLES = 2,
   parameter int CNT_W           = 16,
   parameter int ZR_IDX          = 31
) (
   input logic                   clk,
   input logic                   Reset,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int                WAIT_W    = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_WAIT_CYCLES > 0) ? MEM_WAIT_CYCLES - 1 : 0);
   localparam logic [4:0]        ZR        = 5'(ZR_IDX);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_DONE = 2'b10
   } state_t;

   state_t            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;
   logic              lu;
   logic              stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic              flush_ifid, flush_idex, flush_exmem;

   always_comb begin
      lu = bus.EX_MemRead && (bus.EX_Rd != ZR) &&
           ((bus.ID_UsesRn && (bus.ID_Rn == bus.EX_Rd)) ||
            (bus.ID_UsesRm && (bus.ID_Rm == bus.EX_Rd)));
   end

   always_comb begin
      state_nxt    = RUN;
      wait_cnt_nxt = wait_cnt;
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      stall_idex   = 1'b0;
      stall_exmem  = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      flush_exmem  = 1'b0;
      case (state)
         MEM_WAIT: begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem} = '1;
            // Counter holds cycles left including this one, so leave when it reaches 1 (or 0).
            if (wait_cnt == '0 || wait_cnt == WAIT_W'(1)) begin
               state_nxt = MEM_DONE;
            end else begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = wait_cnt - WAIT_W'(1);
            end
         end
         default: begin
            // RUN, MEM_DONE and the unused encoding; MEM_DONE ignores the finished access.
            if (state != MEM_DONE && bus.MEM_MemAccess && (MEM_WAIT_CYCLES > 0)) begin
               {stall_pc, stall_ifid, stall_idex, stall_exmem} = '1;
               wait_cnt_nxt = WAIT_LOAD;
               state_nxt    = MEM_WAIT;
            end else if (bus.MEM_BranchTaken) begin
               {flush_ifid, flush_idex, flush_exmem} = '1;
            end else if (lu) begin
               stall_pc   = 1'b1;
               stall_ifid = 1'b1;
               flush_idex = 1'b1;
            end
         end
      endcase
      if (Reset) begin
         {stall_pc, stall_ifid, stall_idex, stall_exmem} = '0;
         {flush_ifid, flush_idex, flush_exmem}           = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (stall_pc && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if ((flush_ifid || flush_idex || flush_exmem) && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

   assign bus.PC_Stall    = stall_pc;
   assign bus.IFID_Stall  = stall_ifid;
   assign bus.IDEX_Stall  = stall_idex;
   assign bus.EXMEM_Stall = stall_exmem;
   assign bus.IFID_Flush  = flush_ifid;
   assign bus.IDEX_Flush  = flush_idex;
   assign bus.EXMEM_Flush = flush_exmem;
   assign bus.State       = state;
   assign bus.StallCycles = stall_cnt;
   assign bus.FlushEvents = flush_cnt;
endmodule
